// File: rtl/sad_accumulator_if.sv
// rtl/sad_accumulator_if.sv - difference-stream and frame-result bundle for sad_accumulator
interface sad_accumulator_if #(
    parameter int DIFF_W = 4,
    parameter int SUM_W  = 8
);
    logic              start;
    logic [DIFF_W-1:0] diff;
    logic              diff_valid;
    logic              ready;
    logic              busy;
    logic [SUM_W-1:0]  sum;
    logic              done;
    logic              overflow;

    modport master (
        output start, diff, diff_valid,
        input  ready, busy, sum, done, overflow
    );

    modport slave (
        input  start, diff, diff_valid,
        output ready, busy, sum, done, overflow
    );
endinterface

// File: rtl/sad_accumulator.sv
// rtl/sad_accumulator.sv - saturating sum-of-absolute-differences frame accumulator
module sad_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int DIFF_W    = 4,
    parameter int SUM_W     = 8,
    localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    sad_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t            state;
    state_t            state_next;
    logic              clear;
    logic              accept;
    logic              last;

    logic [SUM_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  sum_q;
    logic              overflow_q;

    // One extra bit catches the carry that signals saturation.
    logic [SUM_W:0]    acc_wide;
    logic              acc_sat;
    logic [SUM_W-1:0]  acc_add;

    assign acc_wide = {1'b0, acc} + {{(SUM_W + 1 - DIFF_W){1'b0}}, bus.diff};
    assign acc_sat  = acc_wide[SUM_W];
    assign acc_add  = acc_sat ? {SUM_W{1'b1}} : acc_wide[SUM_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACCUM;
                    clear      = 1'b1;
                end
            end
            ACCUM: begin
                // A restart wins over any difference presented in the same cycle.
                if (bus.start) begin
                    clear = 1'b1;
                end else if (bus.diff_valid) begin
                    accept = 1'b1;
                    if (count == LAST_CNT) begin
                        last       = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = ACCUM;
                    clear      = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc        <= '0;
            count      <= '0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            acc   <= acc_add;
            count <= count + CNT_W'(1);
            if (acc_sat) begin
                overflow_q <= 1'b1;
            end
            if (last) begin
                sum_q <= acc_add;
            end
        end
    end

    // Handshake outputs decode only the state register, keeping DiffValid off the Ready path.
    assign bus.ready    = (state == ACCUM);
    assign bus.busy     = (state == ACCUM);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sad_accumulator.sv
// tb/tb_sad_accumulator.sv - directed self-checking bench for sad_accumulator
module tb_sad_accumulator;

    logic       CLK;
    logic       RST_N;
    logic       start;
    logic [3:0] diff;
    logic       diff_valid;
    int         passed;
    int         total;

    sad_accumulator_if #(.DIFF_W(4), .SUM_W(8)) bus_a ();
    sad_accumulator_if #(.DIFF_W(4), .SUM_W(6)) bus_b ();

    assign bus_a.start      = start;
    assign bus_a.diff       = diff;
    assign bus_a.diff_valid = diff_valid;
    assign bus_b.start      = start;
    assign bus_b.diff       = diff;
    assign bus_b.diff_valid = diff_valid;

    sad_accumulator #(.N_SAMPLES(8), .DIFF_W(4), .SUM_W(8)) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_a)
    );

    sad_accumulator #(.N_SAMPLES(8), .DIFF_W(4), .SUM_W(6)) dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] v, output logic da, output logic db);
        diff_valid = 1'b1;
        diff       = v;
        step();
        da         = bus_a.done;
        db         = bus_b.done;
        diff_valid = 1'b0;
        diff       = 4'd0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; start = 1'b0; diff = 4'd0; diff_valid = 1'b0;
        #12;
        total++; if ({bus_a.ready, bus_a.busy, bus_a.done, bus_a.overflow} !== 4'b0000) $display("FAIL reset_ctrl_a: got %b want 0000", {bus_a.ready, bus_a.busy, bus_a.done, bus_a.overflow}); else passed++;
        total++; if (bus_a.sum !== 8'd0 || bus_b.sum !== 6'd0) $display("FAIL reset_sum: got %0d/%0d want 0/0", bus_a.sum, bus_b.sum); else passed++;
        #2 RST_N = 1'b1;
        step();
        step();
        total++; if (bus_a.ready !== 1'b0 || bus_b.ready !== 1'b0) $display("FAIL reset_idle_ready: got %b%b want 00", bus_a.ready, bus_b.ready); else passed++;
    endtask

    task automatic test_nominal();
        logic da, db;
        pulse_start();
        total++; if ({bus_a.ready, bus_a.busy} !== 2'b11) $display("FAIL nominal_accum_ctrl: got %b want 11", {bus_a.ready, bus_a.busy}); else passed++;
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), da, db);
            if (i < 8) begin
                total++; if ({da, db} !== 2'b00) $display("FAIL nominal_early_done: got %b%b want 00 at sample %0d", da, db, i); else passed++;
            end
        end
        total++; if ({da, db} !== 2'b11) $display("FAIL nominal_done: got %b%b want 11", da, db); else passed++;
        total++; if (bus_a.sum !== 8'd36 || bus_b.sum !== 6'd36) $display("FAIL nominal_sum: got %0d/%0d want 36/36", bus_a.sum, bus_b.sum); else passed++;
        total++; if ({bus_a.ready, bus_a.busy, bus_a.overflow} !== 3'b000) $display("FAIL nominal_done_ctrl: got %b want 000", {bus_a.ready, bus_a.busy, bus_a.overflow}); else passed++;
        step();
        total++; if ({bus_a.done, bus_a.ready} !== 2'b00) $display("FAIL nominal_done_width: got %b want 00", {bus_a.done, bus_a.ready}); else passed++;
        total++; if (bus_a.sum !== 8'd36) $display("FAIL nominal_sum_hold: got %0d want 36", bus_a.sum); else passed++;
    endtask

    task automatic test_gapped_saturation();
        logic da, db;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            repeat (1 + (i % 3)) begin
                step();
                total++; if ({bus_a.done, bus_a.ready} !== 2'b01) $display("FAIL gapped_idle_cycle: got %b want 01", {bus_a.done, bus_a.ready}); else passed++;
            end
            send(4'd15, da, db);
            if (i < 7) begin
                total++; if ({da, db} !== 2'b00) $display("FAIL gapped_early_done: got %b%b want 00 at sample %0d", da, db, i); else passed++;
            end
        end
        total++; if ({da, db} !== 2'b11) $display("FAIL gapped_done: got %b%b want 11", da, db); else passed++;
        total++; if (bus_a.sum !== 8'd120 || bus_a.overflow !== 1'b0) $display("FAIL gapped_sum_a: got %0d ov %b want 120 ov 0", bus_a.sum, bus_a.overflow); else passed++;
        total++; if (bus_b.sum !== 6'd63 || bus_b.overflow !== 1'b1) $display("FAIL saturate_sum_b: got %0d ov %b want 63 ov 1", bus_b.sum, bus_b.overflow); else passed++;
        step();
        total++; if (bus_b.overflow !== 1'b1) $display("FAIL saturate_sticky: got %b want 1", bus_b.overflow); else passed++;
        pulse_start();
        total++; if (bus_b.overflow !== 1'b0) $display("FAIL start_clears_overflow: got %b want 0", bus_b.overflow); else passed++;
        for (int i = 0; i < 8; i++) send(4'd1, da, db);
        total++; if (bus_a.sum !== 8'd8 || bus_b.sum !== 6'd8 || bus_b.overflow !== 1'b0) $display("FAIL post_sat_sum: got %0d/%0d ov %b want 8/8 ov 0", bus_a.sum, bus_b.sum, bus_b.overflow); else passed++;
        step();
    endtask

    task automatic test_restart();
        logic da, db;
        pulse_start();
        for (int i = 0; i < 5; i++) send(4'd9, da, db);
        total++; if ({da, db} !== 2'b00) $display("FAIL restart_pre_done: got %b%b want 00", da, db); else passed++;
        start = 1'b1; diff_valid = 1'b1; diff = 4'd9;
        step();
        start = 1'b0; diff_valid = 1'b0; diff = 4'd0;
        total++; if ({bus_a.ready, bus_a.done} !== 2'b10) $display("FAIL restart_stays_accum: got %b want 10", {bus_a.ready, bus_a.done}); else passed++;
        for (int i = 1; i <= 8; i++) begin
            send(4'd2, da, db);
            if (i < 8) begin
                total++; if ({da, db} !== 2'b00) $display("FAIL restart_early_done: got %b%b want 00 at sample %0d", da, db, i); else passed++;
            end
        end
        total++; if ({da, db} !== 2'b11 || bus_a.sum !== 8'd16) $display("FAIL restart_sum: got done %b%b sum %0d want 11 sum 16", da, db, bus_a.sum); else passed++;
        step();
    endtask

    task automatic test_ignored();
        logic da, db;
        diff_valid = 1'b1; diff = 4'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if ({bus_a.ready, bus_a.busy, bus_a.done} !== 3'b000) $display("FAIL ignored_idle: got %b want 000 at cycle %0d", {bus_a.ready, bus_a.busy, bus_a.done}, i); else passed++;
        end
        pulse_start();
        diff_valid = 1'b0; diff = 4'd0;
        for (int i = 0; i < 8; i++) send(4'd0, da, db);
        total++; if ({da, db} !== 2'b11 || bus_a.sum !== 8'd0 || bus_a.overflow !== 1'b0) $display("FAIL ignored_sum: got done %b%b sum %0d ov %b want 11 0 0", da, db, bus_a.sum, bus_a.overflow); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        logic da, db;
        pulse_start();
        for (int i = 0; i < 8; i++) send(4'd1, da, db);
        total++; if ({da, bus_a.sum} !== {1'b1, 8'd8}) $display("FAIL b2b_first_frame: got done %b sum %0d want 1 8", da, bus_a.sum); else passed++;
        pulse_start();
        total++; if ({bus_a.ready, bus_a.done} !== 2'b10) $display("FAIL b2b_start_in_done: got %b want 10", {bus_a.ready, bus_a.done}); else passed++;
        for (int i = 0; i < 8; i++) send(4'd3, da, db);
        total++; if ({da, bus_a.sum} !== {1'b1, 8'd24}) $display("FAIL b2b_second_frame: got done %b sum %0d want 1 24", da, bus_a.sum); else passed++;
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic da, db;
        pulse_start();
        for (int i = 0; i < 3; i++) send(4'd5, da, db);
        total++; if (bus_a.ready !== 1'b1) $display("FAIL midreset_pre_ready: got %b want 1", bus_a.ready); else passed++;
        #3 RST_N = 1'b0;
        #1;
        total++; if ({bus_a.ready, bus_a.busy, bus_a.done, bus_a.overflow} !== 4'b0000) $display("FAIL midreset_ctrl: got %b want 0000", {bus_a.ready, bus_a.busy, bus_a.done, bus_a.overflow}); else passed++;
        total++; if (bus_a.sum !== 8'd0 || bus_b.sum !== 6'd0) $display("FAIL midreset_sum: got %0d/%0d want 0/0", bus_a.sum, bus_b.sum); else passed++;
        step();
        #2 RST_N = 1'b1;
        diff_valid = 1'b1; diff = 4'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if ({bus_a.ready, bus_a.busy} !== 2'b00) $display("FAIL midreset_stays_idle: got %b want 00", {bus_a.ready, bus_a.busy}); else passed++;
        end
        diff_valid = 1'b0; diff = 4'd0;
        pulse_start();
        for (int i = 0; i < 8; i++) send(4'd2, da, db);
        total++; if ({da, bus_a.sum} !== {1'b1, 8'd16}) $display("FAIL midreset_resume: got done %b sum %0d want 1 16", da, bus_a.sum); else passed++;
        step();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_nominal();
        test_gapped_saturation();
        test_restart();
        test_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
